// File: rtl/requant_pool2x2_pkg.sv
// Shared types and constants for the requantize + 2x2 max-pool block.
// Holds the frame FSM state encoding, int8 saturation bounds and the product width.
package requant_pool2x2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int PROD_W = 48;

  localparam logic signed [7:0] INT8_MAX = 8'sd127;
  localparam logic signed [7:0] INT8_MIN = -8'sd128;

  function automatic logic signed [7:0] max_s8(input logic signed [7:0] a,
                                                input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/requant_pool2x2_requantizer.sv
// Requantizer: 48-bit product, round-half-up arithmetic shift, int8 saturation.
// One register stage; q_valid follows in_valid by exactly one cycle.
module requant_pool2x2_requantizer
  import requant_pool2x2_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [31:0] pixel_in,
  input  logic        [15:0] mult,
  input  logic        [4:0]  shift,
  output logic               q_valid,
  output logic signed [7:0]  q
);

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W:0]   rnd;
  logic signed [PROD_W:0]   rounded;
  logic signed [PROD_W:0]   shifted;
  logic signed [7:0]        sat;

  always_comb begin
    prod = PROD_W'(signed'(pixel_in)) * PROD_W'(signed'({1'b0, mult}));
    rnd  = '0;
    if (shift != 5'd0) begin
      rnd = (PROD_W + 1)'(1) << (shift - 5'd1);
    end
    // One guard bit keeps the rounding add from wrapping near full scale.
    rounded = (PROD_W + 1)'(prod) + rnd;
    shifted = rounded >>> shift;
    if (shifted > (PROD_W + 1)'(INT8_MAX)) begin
      sat = INT8_MAX;
    end else if (shifted < (PROD_W + 1)'(INT8_MIN)) begin
      sat = INT8_MIN;
    end else begin
      sat = shifted[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else begin
      q_valid <= in_valid;
      if (in_valid) begin
        q <= sat;
      end
    end
  end

endmodule

// File: rtl/requant_pool2x2.sv
// Requantize a raster stream of conv accumulators to int8, then optionally 2x2 max-pool.
// Pipeline: accept -> requant register -> pool/output register (2 cycles in to out).
module requant_pool2x2
  import requant_pool2x2_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [31:0] pixel_in,
  input  logic        [15:0] mult,
  input  logic        [4:0]  shift,
  input  logic        [7:0]  width,
  input  logic        [7:0]  height,
  input  logic               pool_en,
  output logic               out_valid,
  output logic signed [7:0]  pixel_out,
  output logic               frame_done
);

  localparam int LB_DEPTH = IMAGE_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int COL_W    = LB_AW + 1;
  localparam int ROW_W    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  state_t               state_reg;
  logic [COL_W-1:0]     col_reg;
  logic [ROW_W-1:0]     row_reg;
  logic [7:0]           width_reg;
  logic [7:0]           height_reg;
  logic                 pool_reg;

  logic [7:0]           frame_w;
  logic [7:0]           frame_h;
  logic                 frame_pool;
  logic [7:0]           col8;
  logic [7:0]           row8;
  logic [7:0]           w_even;
  logic [7:0]           h_even;
  logic                 start_ok;
  logic                 accept;
  logic                 col_last;
  logic                 row_last;
  logic                 px_last;
  logic                 px_keep;
  logic                 px_final;

  // Frame geometry comes straight from the ports on the starting pixel, latched afterwards.
  assign frame_w    = (state_reg == ST_IDLE) ? width   : width_reg;
  assign frame_h    = (state_reg == ST_IDLE) ? height  : height_reg;
  assign frame_pool = (state_reg == ST_IDLE) ? pool_en : pool_reg;

  assign col8     = 8'(col_reg);
  assign row8     = 8'(row_reg);
  assign w_even   = {frame_w[7:1], 1'b0};
  assign h_even   = {frame_h[7:1], 1'b0};
  assign start_ok = (width >= 8'd2) && (height >= 8'd2);
  assign accept   = in_valid &&
                    (((state_reg == ST_IDLE) && start_ok) || (state_reg == ST_ACTIVE));

  assign col_last = (col8 == frame_w - 8'd1);
  assign row_last = (row8 == frame_h - 8'd1);
  assign px_last  = col_last && row_last;
  // Odd trailing column/row never completes a window, so it is dropped when pooling.
  assign px_keep  = !frame_pool || ((col8 < w_even) && (row8 < h_even));
  assign px_final = frame_pool ? ((col8 == w_even - 8'd1) && (row8 == h_even - 8'd1))
                               : px_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      col_reg    <= '0;
      row_reg    <= '0;
      width_reg  <= '0;
      height_reg <= '0;
      pool_reg   <= 1'b0;
    end else begin
      if (accept) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= px_last ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            width_reg  <= width;
            height_reg <= height;
            pool_reg   <= pool_en;
            state_reg  <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (accept && px_last) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  logic              q_valid;
  logic signed [7:0] q_val;

  requant_pool2x2_requantizer u_requantizer (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept),
    .pixel_in (pixel_in),
    .mult     (mult),
    .shift    (shift),
    .q_valid  (q_valid),
    .q        (q_val)
  );

  // Position tags travel alongside the requant register.
  logic             s1_pool;
  logic             s1_keep;
  logic             s1_col_odd;
  logic             s1_row_odd;
  logic             s1_final;
  logic [LB_AW-1:0] s1_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pool    <= 1'b0;
      s1_keep    <= 1'b0;
      s1_col_odd <= 1'b0;
      s1_row_odd <= 1'b0;
      s1_final   <= 1'b0;
      s1_idx     <= '0;
    end else if (accept) begin
      s1_pool    <= frame_pool;
      s1_keep    <= px_keep;
      s1_col_odd <= col_reg[0];
      s1_row_odd <= row_reg[0];
      s1_final   <= px_final;
      s1_idx     <= col_reg[COL_W-1:1];
    end
  end

  logic signed [7:0] pair_reg;
  logic signed [7:0] linebuf [LB_DEPTH];
  logic signed [7:0] lb_rd_reg;
  logic              lb_we;
  logic [LB_AW-1:0]  lb_addr;
  logic signed [7:0] lb_wdata;

  // Writes happen only on even rows and reads only for odd-row odd-column pixels,
  // and those can never fall in the same cycle, so a single port is enough.
  assign lb_we    = q_valid && s1_pool && s1_keep && s1_col_odd && !s1_row_odd;
  assign lb_addr  = lb_we ? s1_idx : col_reg[COL_W-1:1];
  assign lb_wdata = max_s8(pair_reg, q_val);

  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf[lb_addr] <= lb_wdata;
    end
    lb_rd_reg <= linebuf[lb_addr];
  end

  logic              out_valid_reg;
  logic signed [7:0] pixel_out_reg;
  logic              frame_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      pixel_out_reg  <= '0;
      frame_done_reg <= 1'b0;
      pair_reg       <= '0;
    end else begin
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      if (q_valid) begin
        if (!s1_pool) begin
          out_valid_reg  <= 1'b1;
          pixel_out_reg  <= q_val;
          frame_done_reg <= s1_final;
        end else if (s1_keep) begin
          if (!s1_col_odd) begin
            pair_reg <= q_val;
          end else if (s1_row_odd) begin
            out_valid_reg  <= 1'b1;
            pixel_out_reg  <= max_s8(max_s8(lb_rd_reg, pair_reg), q_val);
            frame_done_reg <= s1_final;
          end
        end
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign pixel_out  = pixel_out_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_requant_pool2x2.sv
// Directed bench for requant_pool2x2: stimulus pushes expected outputs into a queue,
// a monitor pops and compares value, arrival cycle and frame_done on every out_valid.
module tb_requant_pool2x2;
  import requant_pool2x2_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [31:0] pixel_in = '0;
  logic        [15:0] mult = 16'd1;
  logic        [4:0]  shift = 5'd0;
  logic        [7:0]  width = 8'd2;
  logic        [7:0]  height = 8'd2;
  logic               pool_en = 1'b0;
  logic               out_valid;
  logic signed [7:0]  pixel_out;
  logic               frame_done;

  requant_pool2x2 #(.IMAGE_WIDTH(128), .IMAGE_HEIGHT(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .pixel_in   (pixel_in),
    .mult       (mult),
    .shift      (shift),
    .width      (width),
    .height     (height),
    .pool_en    (pool_en),
    .out_valid  (out_valid),
    .pixel_out  (pixel_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
    bit fd;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   out_seen = 0;

  // Frame B and its quad maxima: from linebuf, from the current pixel, from the pair, from linebuf.
  int fb [16] = '{9, 1, -3, -7,  2, 4, -8, -2,  -1, -5, 6, 0,  7, 3, 2, -4};

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          out_seen++;
          $display("out cyc=%0d pixel_out=%0d frame_done=%0d", cyc, pixel_out, frame_done);
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got value %0d, expected no output", pixel_out);
          end else begin
            e = sbq.pop_front();
            check("out_value", int'(pixel_out), e.val);
            check("out_cycle", cyc, e.cyc);
            check("frame_done", int'(frame_done), int'(e.fd));
          end
        end else if (frame_done) begin
          total++;
          bad++;
          $display("FAIL frame_done_alone: got 1 without out_valid, expected 0");
        end
      end
    end
  endtask

  task automatic px(input int v, input int m, input int s,
                    input bit has_exp, input int e, input bit efd);
    @(posedge clk);
    #1;
    pixel_in = v;
    mult     = m[15:0];
    shift    = s[4:0];
    in_valid = 1'b1;
    if (has_exp) sbq.push_back(exp_t'{val: e, cyc: cyc + 2, fd: efd});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_b(input int gap_after);
    width = 8'd4; height = 8'd4; pool_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      px(fb[i], 1, 0, (i == 5 || i == 7 || i == 13 || i == 15),
         (i == 5) ? 9 : (i == 7) ? -2 : (i == 13) ? 7 : 6, (i == 15));
      if (i == gap_after) idle(2);
    end
    drain();
  endtask

  initial begin
    int v;
    int e;
    int seen0;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_pixel_out", int'(pixel_out), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_state", int'(dut.state_reg), int'(ST_IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // requant corners, 2x2 bypass frame
    width = 8'd2; height = 8'd2; pool_en = 1'b0;
    px(1000, 256, 8, 1, 127, 0);
    px(300, 128, 8, 1, 127, 0);
    px(-3, 1, 1, 1, -1, 0);
    px(-1000, 65535, 0, 1, -128, 1);
    drain();

    // rounding and negative saturation
    px(5, 1, 1, 1, 3, 0);
    px(-5, 1, 1, 1, -2, 0);
    px(383, 1, 8, 1, 1, 0);
    px(-129, 1, 0, 1, -128, 1);
    drain();

    // 4x4 pooled ramp 0..15
    width = 8'd4; height = 8'd4; pool_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      px(i, 1, 0, (i == 5 || i == 7 || i == 13 || i == 15), i, (i == 15));
    end
    drain();

    // 4x4 pooled mixed-sign frame with a gap mid-frame
    frame_b(9);

    // 5x3 pooled: column 4 and row 2 dropped
    width = 8'd5; height = 8'd3; pool_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        v = (c == 4 || r == 2) ? 100 : r * 5 + c;
        px(v, 1, 0, (r == 1 && (c == 1 || c == 3)), (c == 1) ? 6 : 8, (r == 1 && c == 3));
      end
    end
    drain();
    check("odd_frame_state_idle", int'(dut.state_reg), int'(ST_IDLE));

    // 4x4 bypass, in_valid every other cycle, saturating ramp
    width = 8'd4; height = 8'd4; pool_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = i * 20 - 150;
      e = (v > 127) ? 127 : ((v < -128) ? -128 : v);
      px(v, 1, 0, 1, e, (i == 15));
      idle(1);
    end
    drain();

    // reset mid-frame after pixel 6, then a fresh frame must not see stale line-buffer data
    width = 8'd4; height = 8'd4; pool_en = 1'b1;
    for (int i = 0; i < 7; i++) px(100, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_frame_done", int'(frame_done), 0);
    check("midreset_state", int'(dut.state_reg), int'(ST_IDLE));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame_b(-1);

    // width=1: frame never starts
    width = 8'd1; height = 8'd4; pool_en = 1'b1;
    seen0 = out_seen;
    for (int i = 0; i < 8; i++) px(50, 1, 0, 0, 0, 0);
    idle(1);
    repeat (5) @(negedge clk);
    check("narrow_outputs", out_seen - seen0, 0);
    check("narrow_state_idle", int'(dut.state_reg), int'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/requant_pool2x2.md
REQUANT_POOL2X2 -- requirements
Module: requant_pool2x2

Interface
REQ-001 Parameter IMAGE_WIDTH, default 128: maximum row length, sizes the line buffer to IMAGE_WIDTH/2 entries.
REQ-002 Parameter IMAGE_HEIGHT, default 128: maximum row count, sizes the row counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  pixel_in carries one convolution result this cycle.
REQ-006 pixel_in  input  32 signed  raster-order 3x3 convolution accumulator output.
REQ-007 mult  input  16 unsigned  requantization multiplier.
REQ-008 shift  input  5  requantization right shift, 0..31.
REQ-009 width  input  8  active row length in pixels.
REQ-010 height  input  8  active row count.
REQ-011 pool_en  input  1  1 = 2x2 max pool, 0 = requantize-only bypass.
REQ-012 out_valid  output  1  pixel_out valid this cycle.
REQ-013 pixel_out  output  8 signed  requantized and, if enabled, pooled pixel.
REQ-014 frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

Function
REQ-015 Requant stage SHALL form prod = pixel_in * mult at 48-bit signed width, with no truncation.
REQ-016 shift>0: q = (prod + 2^(shift-1)) >>> shift, an arithmetic round-half-up; shift=0: q = prod.
REQ-017 q SHALL saturate to [-128, 127]; the result is registered, giving 1 cycle of latency.
REQ-018 FSM states: IDLE, ACTIVE, DRAIN.
REQ-019 IDLE -> ACTIVE on in_valid with width>=2 and height>=2; width, height and pool_en SHALL be latched on that cycle and held for the frame.
REQ-020 In IDLE with width<2 or height<2: in_valid is ignored, there is no output, and the FSM stays in IDLE.
REQ-021 ACTIVE: col and row counters advance on each accepted pixel; col wraps to 0 at width-1 and row increments.
REQ-022 On acceptance of pixel (width-1, height-1) the FSM SHALL go ACTIVE -> DRAIN.
REQ-023 DRAIN -> IDLE once the final output has been issued; in_valid in DRAIN is ignored.
REQ-024 Pool, even col: hold q in a pair register.
REQ-025 Pool, odd col, even row: write max(pair, q) to linebuf[col>>1].
REQ-026 Pool, odd col, odd row: issue max(linebuf[col>>1], pair, q).
REQ-027 Pooled output SHALL be registered: out_valid rises exactly 2 cycles after the in_valid of the bottom-right pixel of each quad.
REQ-028 Odd width: the last column SHALL be discarded. Odd height: the last row SHALL be discarded. No partial windows are emitted.
REQ-029 Bypass (pool_en=0): every accepted pixel SHALL produce one output, 2 cycles after its in_valid, in input order.
REQ-030 Gaps in in_valid SHALL stall the counters without corrupting the pair register or the line buffer; back-to-back input is supported at 1 pixel/cycle.
REQ-031 Comparisons SHALL be signed 8-bit; on a tie, either equal value is acceptable.
REQ-032 frame_done SHALL pulse once per frame, on the same cycle as the final out_valid.

Reset
REQ-033 On rst_n=0, immediately: FSM=IDLE, col=0, row=0, out_valid=0, pixel_out=0, frame_done=0, pipeline valid flags=0.
REQ-034 Line buffer contents need not be reset and SHALL never be read before being written in the same frame.
REQ-035 Reset mid-frame SHALL abandon the frame; the first in_valid after release starts a new frame at (0,0).

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the INT8_MAX/INT8_MIN constants and the 48-bit product width constant.
REQ-037 There SHALL be one sub-module, requantizer, implementing REQ-015..017 combinationally plus its output register.
REQ-038 Line buffer: single-port register array of IMAGE_WIDTH/2 x 8 bits, inferable as RAM.

Verification
REQ-039 Requant corners: pixel_in=1000, mult=256, shift=8 -> 127 (saturated); pixel_in=300, mult=128, shift=8 -> 127; pixel_in=-3, mult=1, shift=1 -> -1; pixel_in=-1000, mult=65535, shift=0 -> -128.
REQ-040 4x4 frame, pool_en=1, mult=1, shift=0, pixels 0..15 raster -> outputs 5, 7, 13, 15, each 2 cycles after inputs 5, 7, 13, 15; frame_done with 15.
REQ-041 5x3 frame, pool_en=1 -> exactly 2 outputs; column 4 and row 2 are ignored; FSM returns to IDLE.
REQ-042 4x4 frame, pool_en=0, in_valid toggling every other cycle -> 16 outputs in order, each 2 cycles after its input; frame_done with the 16th.
REQ-043 rst_n pulsed low after pixel 6 of a 4x4 pooled frame -> out_valid=0 immediately; a fresh 4x4 frame then yields correct maxima with no stale line-buffer data.
REQ-044 width=1, height=4, in_valid held high -> no out_valid, no frame_done, FSM stays in IDLE.
